// File: rtl/spi_slave_global_pkg.sv
// Shared constants for the SPI slave endpoint: slave count, lane mode encoding, FSM states.
// Also holds the miso lane-drive helper used by the shift engine.
package spi_slave_global_pkg;

    localparam int NO_OF_SLAVES = 4;

    localparam logic [1:0] MODE_STD  = 2'b00;
    localparam logic [1:0] MODE_QUAD = 2'b01;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    typedef logic [1:0] state_t;

    // Reserved encodings (1x) fall back to single-lane operation.
    function automatic logic mode_is_quad(input logic [1:0] mode);
        return mode == MODE_QUAD;
    endfunction

endpackage

// File: rtl/spi_slave_shift_engine_if.sv
// Word streams between the SPI shift engine (slave modport) and its user (master modport).
// Both directions are valid/ready; tx_ready is a single-cycle load strobe.
interface spi_slave_shift_engine_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );
endinterface

// File: rtl/spi_slave_shift_engine_sync_edge.sv
// 2-FF synchroniser for an asynchronous pin with single-cycle rise/fall strobes.
// Strobes appear 2-3 pclk after the raw transition; no backpressure.
module spi_sync_edge (
    input  logic pclk,
    input  logic areset,
    input  logic d,
    output logic rise,
    output logic fall
);

    // sr[1:0] is the synchroniser; sr[2] is the edge reference.
    logic [2:0] sr;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            sr <= '0;
        end else begin
            sr <= {sr[1:0], d};
        end
    end

    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_slave_shift_engine.sv
// SPI slave (CPOL=0/CPHA=0, 1 or 4 lanes) oversampled in pclk; rx_valid 3-4 pclk after final sclk rise.
// rx word is overwritten (overflow event) if not accepted in time; tx underflow shifts out zeros.
module spi_slave_shift_engine
    import spi_slave_global_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CS_INDEX   = 0
) (
    input  logic                    pclk,
    input  logic                    areset,
    input  logic                    sclk,
    input  logic [NO_OF_SLAVES-1:0] cs,
    input  logic [1:0]              mode,
    input  logic                    mosi0,
    input  logic                    mosi1,
    input  logic                    mosi2,
    input  logic                    mosi3,
    output logic                    miso0,
    output logic                    miso1,
    output logic                    miso2,
    output logic                    miso3,
    output logic                    miso_oe,
    spi_slave_shift_engine_if.slave stream,
    output logic [1:0]              events_o
);

    localparam int                CNT_W     = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0]  WORD_BITS = CNT_W'(DATA_WIDTH);

    if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("spi_slave_shift_engine: DATA_WIDTH must be a multiple of 4 and at least 8");
    end

    // Only cs[CS_INDEX] matters to this slave; the rest are folded away.
    logic unused_cs;
    assign unused_cs = ^cs;

    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;

    spi_sync_edge u_sclk_sync (
        .pclk   (pclk),
        .areset (areset),
        .d      (sclk),
        .rise   (sclk_rise),
        .fall   (sclk_fall)
    );

    spi_sync_edge u_cs_sync (
        .pclk   (pclk),
        .areset (areset),
        .d      (cs[CS_INDEX]),
        .rise   (cs_rise),
        .fall   (cs_fall)
    );

    // Same depth as the sclk synchroniser so data lines up with the detected rise.
    logic [3:0] mosi_meta, mosi_s;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            mosi_meta <= '0;
            mosi_s    <= '0;
        end else begin
            mosi_meta <= {mosi3, mosi2, mosi1, mosi0};
            mosi_s    <= mosi_meta;
        end
    end

    state_t                state;
    logic                  quad;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [3:0]            miso_q;
    logic                  reload_pend;

    logic [DATA_WIDTH-1:0] rx_shift_nxt;
    logic [DATA_WIDTH-1:0] tx_shift_nxt;
    logic [DATA_WIDTH-1:0] tx_word;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  in_shift;
    logic                  word_done;
    logic                  tx_load;

    function automatic logic [3:0] lane_drive(input logic q, input logic [DATA_WIDTH-1:0] w);
        return q ? w[DATA_WIDTH-1 -: 4] : {3'b000, w[DATA_WIDTH-1]};
    endfunction

    always_comb begin
        rx_shift_nxt = quad ? {rx_shift[DATA_WIDTH-5:0], mosi_s}
                            : {rx_shift, mosi_s[0]};
        tx_shift_nxt = quad ? (tx_shift << 4) : (tx_shift << 1);
        tx_word      = stream.tx_valid ? stream.tx_data : '0;
        cnt_nxt      = bit_cnt + (quad ? CNT_W'(4) : CNT_W'(1));
        in_shift     = (state == ST_SHIFT) && !cs_rise;
        word_done    = in_shift && sclk_rise && (cnt_nxt == WORD_BITS);
        tx_load      = ((state == ST_LOAD) && !cs_rise)
                    || (in_shift && sclk_fall && reload_pend);
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state       <= ST_IDLE;
            quad        <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            miso_q      <= '0;
            miso_oe     <= 1'b0;
            reload_pend <= 1'b0;
        end else if (cs_rise) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            miso_q      <= '0;
            miso_oe     <= 1'b0;
            reload_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state   <= ST_LOAD;
                        quad    <= mode_is_quad(mode);
                        miso_oe <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    tx_shift <= tx_word;
                    miso_q   <= lane_drive(quad, tx_word);
                    state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift <= rx_shift_nxt[DATA_WIDTH-2:0];
                        bit_cnt  <= word_done ? '0 : cnt_nxt;
                        if (word_done) begin
                            reload_pend <= 1'b1;
                        end
                    end
                    // The fall after a completed word starts the next word from the tx stream.
                    if (sclk_fall) begin
                        if (reload_pend) begin
                            tx_shift    <= tx_word;
                            miso_q      <= lane_drive(quad, tx_word);
                            reload_pend <= 1'b0;
                        end else begin
                            tx_shift <= tx_shift_nxt;
                            miso_q   <= lane_drive(quad, tx_shift_nxt);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            stream.rx_data  <= '0;
            stream.rx_valid <= 1'b0;
            stream.tx_ready <= 1'b0;
            events_o        <= '0;
        end else begin
            stream.tx_ready <= tx_load && stream.tx_valid;
            events_o[0]     <= word_done && stream.rx_valid && !stream.rx_ready;
            events_o[1]     <= cs_rise && (bit_cnt != '0);
            // A completing word wins over the accept so a same-cycle handoff keeps rx_valid up.
            if (word_done) begin
                stream.rx_data  <= rx_shift_nxt;
                stream.rx_valid <= 1'b1;
            end else if (stream.rx_valid && stream.rx_ready) begin
                stream.rx_valid <= 1'b0;
            end
        end
    end

    assign {miso3, miso2, miso1, miso0} = miso_q;

endmodule

// File: tb/tb_spi_slave_shift_engine.sv
// Bench for spi_slave_shift_engine: directed cases plus randomized frames against a word-level model.
module tb_spi_slave_shift_engine;
    import spi_slave_global_pkg::*;

    localparam int DW   = 32;
    localparam int CSI  = 1;
    localparam int HALF = 80;

    logic pclk = 1'b0;
    logic areset = 1'b0;
    logic sclk = 1'b0;
    logic [NO_OF_SLAVES-1:0] cs = '1;
    logic [1:0] mode = 2'b00;
    logic mosi0 = 1'b0, mosi1 = 1'b0, mosi2 = 1'b0, mosi3 = 1'b0;
    logic miso0, miso1, miso2, miso3, miso_oe;
    logic [1:0] events_o;

    spi_slave_shift_engine_if #(.DATA_WIDTH(DW)) sif ();

    spi_slave_shift_engine #(.DATA_WIDTH(DW), .CS_INDEX(CSI)) dut (
        .pclk     (pclk),
        .areset   (areset),
        .sclk     (sclk),
        .cs       (cs),
        .mode     (mode),
        .mosi0    (mosi0),
        .mosi1    (mosi1),
        .mosi2    (mosi2),
        .mosi3    (mosi3),
        .miso0    (miso0),
        .miso1    (miso1),
        .miso2    (miso2),
        .miso3    (miso3),
        .miso_oe  (miso_oe),
        .stream   (sif.slave),
        .events_o (events_o)
    );

    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observers: accepted rx words and event pulses.
    logic [DW-1:0] got_q[$];
    int ev_ovf = 0;
    int ev_ferr = 0;

    always @(negedge pclk) begin
        if (sif.rx_valid && sif.rx_ready) got_q.push_back(sif.rx_data);
        if (events_o[0]) ev_ovf++;
        if (events_o[1]) ev_ferr++;
    end

    // tx supplier: presents txq in order, advancing on each tx_ready pulse.
    logic [DW-1:0] txq[$];
    int tx_ld = 0;

    initial begin
        sif.tx_valid = 1'b0;
        sif.tx_data  = '0;
        forever begin
            @(posedge pclk);
            #1;
            if (sif.tx_ready) tx_ld++;
            sif.tx_valid = (tx_ld < txq.size());
            sif.tx_data  = sif.tx_valid ? txq[tx_ld] : '0;
        end
    end

    logic [DW-1:0] mst_tx[4];
    logic [DW-1:0] mst_rx[4];
    bit oe_ok, lane_ok;

    task automatic set_rdy(input logic v);
        @(posedge pclk);
        #1;
        sif.rx_ready = v;
    endtask

    // SPI master: CPOL=0/CPHA=0, drives mst_tx and captures miso into mst_rx at each rise.
    task automatic spi_frame(input logic [1:0] md, input int nwords, input int abort_bits,
                             input bit rst_abort);
        int total, step;
        bit q;
        q     = (md == MODE_QUAD);
        step  = q ? 4 : 1;
        total = (abort_bits > 0) ? abort_bits : nwords * DW;
        oe_ok   = 1'b1;
        lane_ok = 1'b1;
        for (int w = 0; w < 4; w++) mst_rx[w] = '0;
        @(negedge pclk);
        mode    = md;
        cs[CSI] = 1'b0;
        #(HALF + 20);
        for (int b = 0; b < total; b += step) begin
            int wi, pi;
            logic [DW-1:0] wd;
            wi = b / DW;
            pi = b % DW;
            wd = mst_tx[wi];
            if (q) begin
                {mosi3, mosi2, mosi1, mosi0} = wd[DW-1-pi -: 4];
            end else begin
                mosi0 = wd[DW-1-pi];
                mosi1 = 1'($urandom);
                mosi2 = 1'($urandom);
                mosi3 = 1'($urandom);
            end
            #HALF;
            sclk = 1'b1;
            if (!miso_oe) oe_ok = 1'b0;
            if (q) begin
                mst_rx[wi] = {mst_rx[wi][DW-5:0], miso3, miso2, miso1, miso0};
            end else begin
                mst_rx[wi] = {mst_rx[wi][DW-2:0], miso0};
                if ({miso3, miso2, miso1} != 3'b000) lane_ok = 1'b0;
            end
            if (b == 0) mode = 2'($urandom);
            #HALF;
            sclk = 1'b0;
        end
        #HALF;
        if (rst_abort) begin
            areset = 1'b0;
            #40;
            cs[CSI] = 1'b1;
            #40;
            areset = 1'b1;
        end else begin
            cs[CSI] = 1'b1;
        end
        #(HALF * 3);
    endtask

    // Complete frame checked against the word-level model: rx words = sent words, each word
    // slot (frame start plus after every word) consumes the next tx entry or shifts zeros.
    task automatic xfer(input string tag, input logic [1:0] md, input int nwords);
        int ld0, ovf0, ferr0, rd0, avail, exp_pulses;
        logic [DW-1:0] got, exp;
        ld0   = tx_ld;
        ovf0  = ev_ovf;
        ferr0 = ev_ferr;
        rd0   = got_q.size();
        avail = txq.size() - ld0;
        spi_frame(md, nwords, 0, 1'b0);
        check({tag, "_oe_held"}, oe_ok, 1);
        if (md != MODE_QUAD) check({tag, "_idle_lanes"}, lane_ok, 1);
        check({tag, "_rx_count"}, got_q.size() - rd0, nwords);
        for (int w = 0; w < nwords; w++) begin
            got = (rd0 + w < got_q.size()) ? got_q[rd0 + w] : 'x;
            check({tag, "_rx_word"}, got, mst_tx[w]);
            exp = (w < avail) ? txq[ld0 + w] : '0;
            check({tag, "_miso_word"}, mst_rx[w], exp);
        end
        exp_pulses = (nwords + 1 < avail) ? nwords + 1 : avail;
        check({tag, "_tx_ready_pulses"}, tx_ld - ld0, exp_pulses);
        check({tag, "_no_ovf"}, ev_ovf - ovf0, 0);
        check({tag, "_no_ferr"}, ev_ferr - ferr0, 0);
        check({tag, "_oe_after"}, {miso_oe, miso3, miso2, miso1, miso0}, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, ovf0, ferr0, rd0;
        sif.rx_ready = 1'b1;

        repeat (4) @(negedge pclk);
        check("rst_miso", {miso3, miso2, miso1, miso0}, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_rx_data", sif.rx_data, 0);
        check("rst_rx_valid", sif.rx_valid, 0);
        check("rst_tx_ready", sif.tx_ready, 0);
        check("rst_events", events_o, 0);
        areset = 1'b1;
        repeat (4) @(negedge pclk);

        // Empty frame: oe latency, zero drive with no tx word, no events.
        ovf0  = ev_ovf;
        ferr0 = ev_ferr;
        cs[CSI] = 1'b0;
        n = 0;
        do begin
            @(posedge pclk);
            #1;
            n++;
        end while (!miso_oe && n < 20);
        check("oe_latency_3_4", (n >= 3 && n <= 4), 1);
        repeat (4) @(negedge pclk);
        check("empty_miso", {miso3, miso2, miso1, miso0}, 0);
        check("empty_tx_ld", tx_ld, 0);
        cs[CSI] = 1'b1;
        repeat (8) @(negedge pclk);
        check("empty_oe_off", miso_oe, 0);
        check("empty_events", (ev_ovf - ovf0) + (ev_ferr - ferr0), 0);
        check("empty_rx_valid", sif.rx_valid, 0);

        mst_tx[0] = 32'hA5C30F1E;
        txq.push_back(32'h12345678);
        xfer("std", MODE_STD, 1);

        mst_tx[0] = 32'hDEADBEEF;
        txq.push_back(32'hCAFEF00D);
        xfer("quad", MODE_QUAD, 1);

        // Two words with no consumer: one overflow, second word retained.
        set_rdy(1'b0);
        ovf0 = ev_ovf;
        rd0  = got_q.size();
        mst_tx[0] = $urandom;
        mst_tx[1] = $urandom;
        spi_frame(MODE_STD, 2, 0, 1'b0);
        check("ovf_pulses", ev_ovf - ovf0, 1);
        check("ovf_rx_valid", sif.rx_valid, 1);
        check("ovf_rx_data", sif.rx_data, mst_tx[1]);
        check("ovf_nothing_accepted", got_q.size() - rd0, 0);
        set_rdy(1'b1);
        repeat (4) @(negedge pclk);
        check("ovf_drained", got_q.size() - rd0, 1);
        check("ovf_drained_word", (got_q.size() > rd0) ? got_q[rd0] : 'x, mst_tx[1]);
        check("ovf_rx_valid_low", sif.rx_valid, 0);

        // cs released after 13 bits.
        ovf0  = ev_ovf;
        ferr0 = ev_ferr;
        rd0   = got_q.size();
        mst_tx[0] = $urandom;
        spi_frame(MODE_STD, 1, 13, 1'b0);
        check("abort_ferr", ev_ferr - ferr0, 1);
        check("abort_no_ovf", ev_ovf - ovf0, 0);
        check("abort_rx_valid", sif.rx_valid, 0);
        check("abort_no_word", got_q.size() - rd0, 0);
        mst_tx[0] = $urandom;
        xfer("after_abort", MODE_STD, 1);

        // Reset mid-frame after 10 bits, then a clean frame with no tx data.
        ovf0  = ev_ovf;
        ferr0 = ev_ferr;
        mst_tx[0] = $urandom;
        spi_frame(MODE_STD, 1, 10, 1'b1);
        check("rstabort_events", (ev_ovf - ovf0) + (ev_ferr - ferr0), 0);
        check("rstabort_rx_valid", sif.rx_valid, 0);
        check("rstabort_rx_data", sif.rx_data, 0);
        mst_tx[0] = 32'h0000FFFF;
        xfer("post_rst", MODE_STD, 1);

        for (int it = 0; it < 6; it++) begin
            logic [1:0] md;
            int nw, na;
            if ($urandom_range(1, 0) == 1) begin
                md = MODE_QUAD;
            end else begin
                md = ($urandom_range(2, 0) == 0) ? MODE_STD : (2'b10 | 2'($urandom_range(1, 0)));
            end
            nw = $urandom_range(3, 1);
            na = $urandom_range(nw + 1, 0);
            for (int w = 0; w < nw; w++) mst_tx[w] = $urandom;
            for (int k = 0; k < na; k++) txq.push_back($urandom);
            xfer("rnd", md, nw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
